// File: rtl/str_pair_pkg.sv
// Shared entry type for the string-pair FIFO.
// One entry holds two string members and a packed tag.
package str_pair_pkg;
    localparam int TAG_W = 8;

    typedef struct {
        string             fst;
        string             snd;
        logic [TAG_W-1:0]  tag;
    } str_pair_t;

    localparam str_pair_t EMPTY_PAIR = '{"", "", '0};
endpackage

// File: rtl/str_pair_view.sv
// Output view of the FIFO head: optional member swap, forced empty entry when nothing is held.
// Purely combinational, zero latency, no flow control of its own.
module str_pair_view
    import str_pair_pkg::*;
#(
    parameter bit SWAP = 1'b0
) (
    input  logic             i_vld,
    input  str_pair_t        i_pair,
    output string            o_fst,
    output string            o_snd,
    output logic [TAG_W-1:0] o_tag
);

    always_comb begin
        o_fst = "";
        o_snd = "";
        o_tag = '0;
        if (i_vld) begin
            o_fst = SWAP ? i_pair.snd : i_pair.fst;
            o_snd = SWAP ? i_pair.fst : i_pair.snd;
            o_tag = i_pair.tag;
        end
    end

endmodule

// File: rtl/str_pair_fifo.sv
// First-word-fall-through FIFO of string-pair entries; head visible one cycle after a push into empty.
// in_ready drops at full with no same-cycle bypass; refused offers are counted in drops (saturating).
module str_pair_fifo
    import str_pair_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit SWAP         = 1'b0,
    parameter bit CLEAR_ON_POP = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  string                      in_fst,
    input  string                      in_snd,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output string                      out_fst,
    output string                      out_snd,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] peak,
    output logic [15:0]                drops
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH-1);

    str_pair_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_peak;
    logic [15:0]      r_drops;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    str_pair_t        w_in_pair;
    str_pair_t        w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;
    assign peak      = r_peak;
    assign drops     = r_drops;

    always_comb begin
        w_in_pair = '{in_fst, in_snd, in_tag};
        w_head    = r_mem[r_rd_ptr];
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Push and pop can never target the same slot: equal pointers mean empty (no pop) or full (no push).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_peak   <= '0;
            r_drops  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= EMPTY_PAIR;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_pair;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
                if (CLEAR_ON_POP) begin
                    r_mem[r_rd_ptr] <= EMPTY_PAIR;
                end
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_peak) begin
                r_peak <= w_count_nxt;
            end
            if (in_valid && !in_ready && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    str_pair_view #(
        .SWAP (SWAP)
    ) u_view (
        .i_vld  (out_valid),
        .i_pair (w_head),
        .o_fst  (out_fst),
        .o_snd  (out_snd),
        .o_tag  (out_tag)
    );

endmodule

// File: tb/tb_str_pair_fifo.sv
// Drives two FIFO configurations with shared stimulus and checks them against queue-based models.
module tb_str_pair_fifo;
    import str_pair_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    string      in_fst;
    string      in_snd;
    logic [7:0] in_tag;
    logic       out_ready;

    logic        a_in_ready, a_out_valid;
    string       a_out_fst, a_out_snd;
    logic [7:0]  a_out_tag;
    logic [1:0]  a_count, a_peak;
    logic [15:0] a_drops;

    logic        b_in_ready, b_out_valid;
    string       b_out_fst, b_out_snd;
    logic [7:0]  b_out_tag;
    logic [2:0]  b_count, b_peak;
    logic [15:0] b_drops;

    int total = 0;
    int bad   = 0;

    str_pair_t mq [2][$];
    int        mpk [2];
    int        mdr [2];

    str_pair_fifo #(.DEPTH(3), .SWAP(1'b0), .CLEAR_ON_POP(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_fst(in_fst), .in_snd(in_snd), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_fst(a_out_fst), .out_snd(a_out_snd), .out_tag(a_out_tag),
        .count(a_count), .peak(a_peak), .drops(a_drops)
    );

    str_pair_fifo #(.DEPTH(4), .SWAP(1'b1), .CLEAR_ON_POP(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_fst(in_fst), .in_snd(in_snd), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_fst(b_out_fst), .out_snd(b_out_snd), .out_tag(b_out_tag),
        .count(b_count), .peak(b_peak), .drops(b_drops)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dep(input int idx);
        return (idx == 0) ? 3 : 4;
    endfunction

    task automatic chk_num(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", name, idx, $time, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input int idx, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=\"%s\" want=\"%s\"", name, idx, $time, act, exp);
        end
    endtask

    // Compare one instance against its model, then advance the model across the coming edge.
    task automatic check_inst(input int idx, input logic irdy, input logic ovld,
                              input string of, input string os, input logic [7:0] ot,
                              input logic [31:0] cnt, input logic [31:0] pk, input logic [31:0] dr);
        int        sz;
        int        d;
        bit        swp;
        bit        push;
        bit        pop;
        str_pair_t h;
        string     ef;
        string     es;
        logic [7:0] et;
        sz  = mq[idx].size();
        d   = dep(idx);
        swp = (idx == 1);
        chk_num("in_ready",  idx, {31'd0, irdy}, {31'd0, sz < d});
        chk_num("out_valid", idx, {31'd0, ovld}, {31'd0, sz != 0});
        chk_num("count",     idx, cnt, sz);
        chk_num("peak",      idx, pk,  mpk[idx]);
        chk_num("drops",     idx, dr,  mdr[idx]);
        ef = ""; es = ""; et = 8'h00;
        if (sz != 0) begin
            h  = mq[idx][0];
            ef = swp ? h.snd : h.fst;
            es = swp ? h.fst : h.snd;
            et = h.tag;
        end
        chk_str("out_fst", idx, of, ef);
        chk_str("out_snd", idx, os, es);
        chk_num("out_tag", idx, {24'd0, ot}, {24'd0, et});
        if (rst) begin
            mq[idx].delete();
            mpk[idx] = 0;
            mdr[idx] = 0;
        end else begin
            push = in_valid && (sz < d);
            pop  = (sz != 0) && out_ready;
            if (in_valid && !(sz < d) && mdr[idx] < 65535) mdr[idx]++;
            if (pop)  void'(mq[idx].pop_front());
            if (push) mq[idx].push_back('{in_fst, in_snd, in_tag});
            if (mq[idx].size() > mpk[idx]) mpk[idx] = mq[idx].size();
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, a_in_ready, a_out_valid, a_out_fst, a_out_snd, a_out_tag,
                   {30'd0, a_count}, {30'd0, a_peak}, {16'd0, a_drops});
        check_inst(1, b_in_ready, b_out_valid, b_out_fst, b_out_snd, b_out_tag,
                   {29'd0, b_count}, {29'd0, b_peak}, {16'd0, b_drops});
    end

    task automatic cyc(input logic r, input logic v, input string f, input string s,
                       input logic [7:0] t, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_fst    = f;
        in_snd    = s;
        in_tag    = t;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, "", "", 8'h00, ordy);
    endtask

    initial begin
        mpk[0] = 0; mpk[1] = 0; mdr[0] = 0; mdr[1] = 0;
        rst = 1'b1; in_valid = 1'b0; in_fst = ""; in_snd = ""; in_tag = 8'h00; out_ready = 1'b0;
        cyc(1'b1, 1'b0, "", "", 8'h00, 1'b0);
        cyc(1'b1, 1'b0, "", "", 8'h00, 1'b0);

        // Basic fall-through and ordering.
        cyc(1'b0, 1'b1, "hello", "world", 8'h01, 1'b0);
        cyc(1'b0, 1'b1, "test-word-1", "test-word-2", 8'h02, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Overfill, full with simultaneous offer and pop, then refill and drain.
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, $sformatf("f%0d", k), $sformatf("g%0d", k), 8'(k), 1'b0);
        cyc(1'b0, 1'b1, "x5", "y5", 8'h05, 1'b1);
        cyc(1'b0, 1'b1, "x6", "y6", 8'h06, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 6);

        // Swapped view on the second instance.
        cyc(1'b0, 1'b1, "a", "b", 8'h07, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Steady stream at one push and one pop per cycle.
        cyc(1'b0, 1'b1, "p0", "q0", 8'h10, 1'b0);
        for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b1, $sformatf("p%0d", k), $sformatf("q%0d", k), 8'(8'h10 + k), 1'b1);
        idle(1'b1, 3);

        // Mid-stream reset with a push in the reset cycle.
        cyc(1'b0, 1'b1, "r0", "s0", 8'h20, 1'b0);
        cyc(1'b0, 1'b1, "r1", "s1", 8'h21, 1'b0);
        cyc(1'b1, 1'b1, "r2", "s2", 8'h22, 1'b1);
        idle(1'b0, 1);
        cyc(1'b0, 1'b1, "fresh", "entry", 8'h33, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 2);

        // Random traffic with occasional resets.
        for (int k = 0; k < 2000; k++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 99) < 60),
                ($urandom_range(0, 9) == 0) ? "" : $sformatf("u%0d", $urandom_range(0, 999)),
                $sformatf("v%0d", $urandom_range(0, 999)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 99) < 50));
        end
        idle(1'b1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
